// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: two upstream command ports, the SDRAM controller command port and arbiter status
interface sdram_port_arbiter_if #(
    parameter int AddrWidth = 23,
    parameter int DataWidth = 16,
    parameter int TagDepth  = 8
);
    logic                       p0Trigger, p0Write, p0Ready, p0ReadDataValid;
    logic [AddrWidth-1:0]       p0Addr;
    logic [DataWidth-1:0]       p0WriteData, p0ReadData;
    logic                       p1Trigger, p1Write, p1Ready, p1ReadDataValid;
    logic [AddrWidth-1:0]       p1Addr;
    logic [DataWidth-1:0]       p1WriteData, p1ReadData;
    logic                       cmdTrigger, cmdWrite, cmdReady, cmdReadDataValid;
    logic [AddrWidth-1:0]       cmdAddr;
    logic [DataWidth-1:0]       cmdWriteData, cmdReadData;
    logic [$clog2(TagDepth):0]  outstanding;
    logic                       errUnexpectedRead;

    modport slave (
        input  p0Trigger, p0Write, p0Addr, p0WriteData,
        input  p1Trigger, p1Write, p1Addr, p1WriteData,
        input  cmdReady, cmdReadData, cmdReadDataValid,
        output p0Ready, p0ReadData, p0ReadDataValid,
        output p1Ready, p1ReadData, p1ReadDataValid,
        output cmdTrigger, cmdWrite, cmdAddr, cmdWriteData,
        output outstanding, errUnexpectedRead
    );

    modport master (
        output p0Trigger, p0Write, p0Addr, p0WriteData,
        output p1Trigger, p1Write, p1Addr, p1WriteData,
        output cmdReady, cmdReadData, cmdReadDataValid,
        input  p0Ready, p0ReadData, p0ReadDataValid,
        input  p1Ready, p1ReadData, p1ReadDataValid,
        input  cmdTrigger, cmdWrite, cmdAddr, cmdWriteData,
        input  outstanding, errUnexpectedRead
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port round-robin burst arbiter for an SDRAM controller with in-order read-data routing
module sdram_port_arbiter #(
    parameter int AddrWidth = 23,
    parameter int DataWidth = 16,
    parameter int TagDepth  = 8,
    parameter int MaxBurst  = 16
) (
    input logic                 clk,
    input logic                 rst_,
    sdram_port_arbiter_if.slave bus
);
    localparam int TW = $clog2(TagDepth);
    localparam int BW = $clog2(MaxBurst) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]    state;
    logic          last_grant;
    logic [BW-1:0] burst;
    logic [TW-1:0] wr_ptr, rd_ptr;
    logic [TW:0]   count;
    logic          tags [TagDepth];
    logic          err;
    logic          grant, own_trig, other_trig, own_write, hold, tag_full;
    logic          cmd_trig, accept, push, pop, rd_id;

    // Round-robin only matters in IDLE with both requesting; an owner keeps the grant.
    assign grant      = state == OWN1 || (state == IDLE && (bus.p0Trigger && bus.p1Trigger ? !last_grant : bus.p1Trigger));
    assign own_trig   = grant ? bus.p1Trigger : bus.p0Trigger;
    assign other_trig = grant ? bus.p0Trigger : bus.p1Trigger;
    assign own_write  = grant ? bus.p1Write : bus.p0Write;
    // A full burst with a waiting peer spends one cycle handing back to IDLE without accepting.
    assign hold       = state != IDLE && burst == BW'(MaxBurst) && other_trig;
    assign tag_full   = count == (TW + 1)'(TagDepth);
    assign cmd_trig   = rst_ && own_trig && !hold && (own_write || !tag_full);
    assign accept     = cmd_trig && bus.cmdReady;
    assign push       = accept && !own_write;
    assign pop        = bus.cmdReadDataValid && count != '0;
    assign rd_id      = tags[rd_ptr];

    assign bus.cmdTrigger        = cmd_trig;
    assign bus.cmdWrite          = own_write;
    assign bus.cmdAddr           = grant ? bus.p1Addr : bus.p0Addr;
    assign bus.cmdWriteData      = grant ? bus.p1WriteData : bus.p0WriteData;
    assign bus.p0Ready           = rst_ && bus.cmdReady && !grant && !hold && (bus.p0Write || !tag_full);
    assign bus.p1Ready           = rst_ && bus.cmdReady && grant && !hold && (bus.p1Write || !tag_full);
    assign bus.p0ReadData        = bus.cmdReadData;
    assign bus.p1ReadData        = bus.cmdReadData;
    assign bus.p0ReadDataValid   = rst_ && pop && !rd_id;
    assign bus.p1ReadDataValid   = rst_ && pop && rd_id;
    assign bus.outstanding       = count;
    assign bus.errUnexpectedRead = err;

    // Grant state machine: IDLE picks a port, OWNn holds it until it lets go or its burst expires.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst      <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                state      <= grant ? OWN1 : OWN0;
                last_grant <= grant;
                burst      <= BW'(1);
            end
        end else if (!own_trig || hold) begin
            state <= IDLE;
            burst <= '0;
        end else if (accept) begin
            burst <= burst == BW'(MaxBurst) ? BW'(1) : burst + BW'(1);
        end
    end

    // Tag FIFO pointers, occupancy and the sticky unexpected-read flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + TW'(1);
            if (pop) rd_ptr <= rd_ptr + TW'(1);
            count <= count + {{TW{1'b0}}, push} - {{TW{1'b0}}, pop};
            err   <= err || (bus.cmdReadDataValid && count == '0);
        end
    end

    // Tag storage needs no reset: entries are only read behind valid occupancy.
    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= grant;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed vector table plus multi-cycle corner sequences for sdram_port_arbiter
module tb_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam int TD = 8;
    localparam int MB = 16;

    typedef struct {
        logic t0, w0, t1, w1;
        logic [AW-1:0] a0, a1;
        logic rdy, rdv;
        logic [DW-1:0] rd;
        logic ct, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cwd;
        logic r0, r1, v0, v1;
        logic [3:0] outs;
        logic err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int total = 0;
    int bad = 0;
    vec_t vec [10];

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .TagDepth(TD)) bus ();

    sdram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .TagDepth(TD), .MaxBurst(MB)) dut (
        .clk(clk),
        .rst_(rst_),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.p0Trigger = 0; bus.p0Write = 0; bus.p0Addr = '0; bus.p0WriteData = '0;
        bus.p1Trigger = 0; bus.p1Write = 0; bus.p1Addr = '0; bus.p1WriteData = '0;
        bus.cmdReady = 1; bus.cmdReadData = '0; bus.cmdReadDataValid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, p0_before, p0_after, mux_err, both_rdy, got;
        logic exp_id [3];
        // reset holds all outputs quiet even with every input active
        idle_in();
        bus.p0Trigger = 1; bus.p1Trigger = 1; bus.cmdReadDataValid = 1;
        #3;
        chk("rst cmdTrigger", bus.cmdTrigger, 0);
        chk("rst p0Ready", bus.p0Ready, 0);
        chk("rst p1Ready", bus.p1Ready, 0);
        chk("rst p0Valid", bus.p0ReadDataValid, 0);
        chk("rst p1Valid", bus.p1ReadDataValid, 0);
        chk("rst outstanding", bus.outstanding, 0);
        repeat (2) @(posedge clk);
        chk("rst err", bus.errUnexpectedRead, 0);
        @(negedge clk);
        idle_in();
        rst_ = 1;
        tick();
        chk("post-rst err", bus.errUnexpectedRead, 0);

        // t0 w0 t1 w1 a0 a1 rdy rdv rd | ct cw ca cwd r0 r1 v0 v1 outs err
        vec[0] = '{1,0,1,0,'h10,'h20,1,0,'h0000, 1,0,'h10,'hA010,1,0,0,0,0,0};
        vec[1] = '{0,0,1,0,'h10,'h20,1,0,'h0000, 0,0,'h10,'hA010,1,0,0,0,1,0};
        vec[2] = '{0,0,1,0,'h10,'h20,1,0,'h0000, 1,0,'h20,'hB020,0,1,0,0,1,0};
        vec[3] = '{0,0,0,0,'h10,'h20,1,1,'hBEEF, 0,0,'h20,'hB020,0,1,1,0,2,0};
        vec[4] = '{0,0,0,0,'h10,'h20,1,1,'hCAFE, 0,0,'h10,'hA010,1,0,0,1,1,0};
        vec[5] = '{0,0,0,0,'h10,'h20,0,0,'h0000, 0,0,'h10,'hA010,0,0,0,0,0,0};
        vec[6] = '{0,0,1,1,'h10,'h30,1,0,'h0000, 1,1,'h30,'hB030,0,1,0,0,0,0};
        vec[7] = '{1,1,0,1,'h40,'h30,1,0,'h0000, 0,1,'h30,'hB030,0,1,0,0,0,0};
        vec[8] = '{1,1,0,1,'h40,'h30,1,0,'h0000, 1,1,'h40,'hA040,1,0,0,0,0,0};
        vec[9] = '{0,1,0,1,'h40,'h30,0,0,'h0000, 0,1,'h40,'hA040,0,0,0,0,0,0};
        for (int i = 0; i < 10; i++) begin
            bus.p0Trigger = vec[i].t0; bus.p0Write = vec[i].w0; bus.p0Addr = vec[i].a0;
            bus.p0WriteData = 16'hA000 + vec[i].a0[15:0];
            bus.p1Trigger = vec[i].t1; bus.p1Write = vec[i].w1; bus.p1Addr = vec[i].a1;
            bus.p1WriteData = 16'hB000 + vec[i].a1[15:0];
            bus.cmdReady = vec[i].rdy; bus.cmdReadDataValid = vec[i].rdv; bus.cmdReadData = vec[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d cmdTrigger", i), bus.cmdTrigger, vec[i].ct);
            chk($sformatf("v%0d cmdWrite", i), bus.cmdWrite, vec[i].cw);
            chk($sformatf("v%0d cmdAddr", i), bus.cmdAddr, vec[i].ca);
            chk($sformatf("v%0d cmdWriteData", i), bus.cmdWriteData, vec[i].cwd);
            chk($sformatf("v%0d p0Ready", i), bus.p0Ready, vec[i].r0);
            chk($sformatf("v%0d p1Ready", i), bus.p1Ready, vec[i].r1);
            chk($sformatf("v%0d p0Valid", i), bus.p0ReadDataValid, vec[i].v0);
            chk($sformatf("v%0d p1Valid", i), bus.p1ReadDataValid, vec[i].v1);
            chk($sformatf("v%0d p0ReadData", i), bus.p0ReadData, vec[i].rd);
            chk($sformatf("v%0d p1ReadData", i), bus.p1ReadData, vec[i].rd);
            chk($sformatf("v%0d outstanding", i), bus.outstanding, vec[i].outs);
            chk($sformatf("v%0d err", i), bus.errUnexpectedRead, vec[i].err);
            tick();
        end

        // lone requester past MaxBurst keeps streaming with no gap
        idle_in();
        n0 = 0;
        for (int c = 0; c < 20; c++) begin
            bus.p0Trigger = 1; bus.p0Write = 1; bus.p0Addr = AW'(c);
            @(negedge clk);
            if (bus.p0Ready && bus.cmdTrigger) n0++;
            tick();
        end
        chk("solo burst accepts", n0, 20);
        idle_in();
        repeat (2) tick();

        // port 0 streams 40 writes while port 1 asks for one
        n0 = 0; n1 = 0; p0_before = -1; p0_after = 0; mux_err = 0; both_rdy = 0;
        for (int c = 0; c < 100 && !(n0 == 40 && n1 == 1); c++) begin
            bus.p0Trigger = n0 < 40; bus.p0Write = 1; bus.p0Addr = AW'(n0); bus.p0WriteData = DW'(n0);
            bus.p1Trigger = c >= 1 && n1 < 1; bus.p1Write = 1; bus.p1Addr = 'h7777; bus.p1WriteData = 'h5555;
            @(negedge clk);
            if (bus.p0Ready && bus.p1Ready) both_rdy++;
            if (bus.p0Trigger && bus.p0Ready) begin
                if (bus.cmdWriteData !== DW'(n0) || bus.cmdAddr !== AW'(n0) || !bus.cmdTrigger) mux_err++;
                if (n1 > 0) p0_after++;
                n0++;
            end
            if (bus.p1Trigger && bus.p1Ready) begin
                if (bus.cmdWriteData !== 16'h5555 || bus.cmdAddr !== 23'h7777 || !bus.cmdTrigger) mux_err++;
                if (p0_before < 0) p0_before = n0;
                n1++;
            end
            tick();
        end
        chk("p0 accepts before p1", p0_before, MB);
        chk("p1 accepts", n1, 1);
        chk("p0 resumes after p1", p0_after > 0, 1);
        chk("p0 total accepts", n0, 40);
        chk("burst cmd mux", mux_err, 0);
        chk("both readies", both_rdy, 0);
        idle_in();
        repeat (2) tick();

        // fill the tag FIFO with stalled reads, then a write from port 1 still gets through
        n0 = 0;
        for (int c = 0; c < 30 && n0 < 8; c++) begin
            bus.p0Trigger = 1; bus.p0Write = 0; bus.p0Addr = AW'('h100 + n0);
            @(negedge clk);
            if (bus.p0Ready && bus.cmdTrigger) n0++;
            tick();
        end
        @(negedge clk);
        chk("full outstanding", bus.outstanding, 8);
        chk("9th read p0Ready", bus.p0Ready, 0);
        chk("9th read cmdTrigger", bus.cmdTrigger, 0);
        tick();
        bus.p0Trigger = 0;
        bus.p1Trigger = 1; bus.p1Write = 1; bus.p1Addr = 'h300; bus.p1WriteData = 'h1234;
        got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            @(negedge clk);
            if (bus.p1Ready && bus.cmdTrigger && bus.cmdWrite && bus.cmdAddr == 23'h300) got = 1;
            tick();
        end
        chk("write while full", got, 1);
        chk("outstanding after write", bus.outstanding, 8);
        bus.p1Trigger = 0;
        tick();

        // drain to 3, then read data and a new read accept in the same cycle
        bus.cmdReadDataValid = 1;
        for (int k = 0; k < 5; k++) begin
            bus.cmdReadData = DW'(k);
            @(negedge clk);
            chk($sformatf("drain%0d p0Valid", k), bus.p0ReadDataValid, 1);
            chk($sformatf("drain%0d p1Valid", k), bus.p1ReadDataValid, 0);
            tick();
        end
        bus.cmdReadDataValid = 0;
        chk("outstanding 3", bus.outstanding, 3);
        bus.p1Trigger = 1; bus.p1Write = 0; bus.p1Addr = 'h200; bus.cmdReadDataValid = 1;
        @(negedge clk);
        chk("push+pop p1Ready", bus.p1Ready, 1);
        chk("push+pop cmdTrigger", bus.cmdTrigger, 1);
        chk("push+pop p0Valid", bus.p0ReadDataValid, 1);
        chk("push+pop p1Valid", bus.p1ReadDataValid, 0);
        tick();
        bus.p1Trigger = 0; bus.cmdReadDataValid = 0;
        @(negedge clk);
        chk("push+pop outstanding", bus.outstanding, 3);
        tick();
        exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 1;
        bus.cmdReadDataValid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("tail%0d p0Valid", k), bus.p0ReadDataValid, !exp_id[k]);
            chk($sformatf("tail%0d p1Valid", k), bus.p1ReadDataValid, exp_id[k]);
            tick();
        end
        bus.cmdReadDataValid = 0;
        chk("drained outstanding", bus.outstanding, 0);
        chk("no err yet", bus.errUnexpectedRead, 0);

        // read data with nothing pending
        bus.cmdReadDataValid = 1; bus.cmdReadData = 'hDEAD;
        @(negedge clk);
        chk("stray p0Valid", bus.p0ReadDataValid, 0);
        chk("stray p1Valid", bus.p1ReadDataValid, 0);
        tick();
        bus.cmdReadDataValid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("err sticky%0d", k), bus.errUnexpectedRead, 1);
            tick();
        end
        chk("stray outstanding", bus.outstanding, 0);

        // reset mid-operation with two reads in flight
        n0 = 0;
        for (int c = 0; c < 10 && n0 < 2; c++) begin
            bus.p0Trigger = 1; bus.p0Write = 0; bus.p0Addr = 'h400;
            @(negedge clk);
            if (bus.p0Ready && bus.cmdTrigger) n0++;
            tick();
        end
        bus.p0Trigger = 0;
        chk("pre-reset outstanding", bus.outstanding, 2);
        bus.p0Trigger = 1; bus.p1Trigger = 1; bus.cmdReadDataValid = 1;
        rst_ = 0;
        #1;
        chk("mid-rst cmdTrigger", bus.cmdTrigger, 0);
        chk("mid-rst p0Ready", bus.p0Ready, 0);
        chk("mid-rst p1Ready", bus.p1Ready, 0);
        chk("mid-rst p0Valid", bus.p0ReadDataValid, 0);
        chk("mid-rst p1Valid", bus.p1ReadDataValid, 0);
        chk("mid-rst outstanding", bus.outstanding, 0);
        chk("mid-rst err", bus.errUnexpectedRead, 0);
        @(negedge clk);
        idle_in();
        rst_ = 1;
        tick();
        bus.cmdReadDataValid = 1;
        @(negedge clk);
        chk("post-rst data p0Valid", bus.p0ReadDataValid, 0);
        chk("post-rst data p1Valid", bus.p1ReadDataValid, 0);
        tick();
        bus.cmdReadDataValid = 0;
        chk("post-rst data err", bus.errUnexpectedRead, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
